seg_display_driver: RTL and testbench

- Downstream consumer of the 4-digit anode scanner on the board-verification display path.
- Holds a 16-bit hex display word, four decimal points and a write handshake toward the CPU/debug side.
- Double-buffers the word, swapping only at frame boundaries so no digit tears.
- Decodes the nibble selected by the scanner's one-hot anode into registered 7-segment drive, with the anode re-registered to stay aligned.

---
 rtl/seg_display_driver.sv | 131 +++++++++++++
 tb/tb_seg_display_driver.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// Double-buffered 4-digit hex display word feeding registered 7-segment drive.
// The shadow word is promoted to the active word only at a frame boundary, so digits never tear.
module seg_display_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        wr_ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an_o,
  output logic        frame_start
);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic [15:0] r_shadowWord;
  logic [3:0]  r_shadowDp;
  logic [15:0] r_activeWord;
  logic [3:0]  r_activeDp;
  logic        r_pending;
  logic [3:0]  r_prevAn;

  logic        w_fs;
  logic        w_wrAccept;
  logic        w_swap;
  logic [3:0]  w_nibble;
  logic        w_dpBit;
  logic        w_legal;
  logic        w_blank;
  logic [6:0]  w_hex;
  logic [6:0]  w_segRaw;
  logic        w_dpRaw;

  assign wr_ready   = ~r_pending;
  assign w_fs       = (an == 4'b1000) && (r_prevAn == 4'b0001);
  assign w_wrAccept = wr_en && !r_pending;
  assign w_swap     = w_fs && r_pending;

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    w_nibble = 4'h0;
    w_dpBit  = 1'b0;
    w_legal  = 1'b1;
    w_blank  = 1'b0;
    case (an)
      4'b1000: begin
        w_nibble = r_activeWord[15:12];
        w_dpBit  = r_activeDp[3];
        w_blank  = LZ_BLANK && (r_activeWord[15:12] == 4'h0);
      end
      4'b0100: begin
        w_nibble = r_activeWord[11:8];
        w_dpBit  = r_activeDp[2];
        w_blank  = LZ_BLANK && (r_activeWord[15:8] == 8'h00);
      end
      4'b0010: begin
        w_nibble = r_activeWord[7:4];
        w_dpBit  = r_activeDp[1];
        w_blank  = LZ_BLANK && (r_activeWord[15:4] == 12'h000);
      end
      4'b0001: begin
        w_nibble = r_activeWord[3:0];
        w_dpBit  = r_activeDp[0];
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (w_nibble)
      4'h0:    w_hex = 7'h3F;
      4'h1:    w_hex = 7'h06;
      4'h2:    w_hex = 7'h5B;
      4'h3:    w_hex = 7'h4F;
      4'h4:    w_hex = 7'h66;
      4'h5:    w_hex = 7'h6D;
      4'h6:    w_hex = 7'h7D;
      4'h7:    w_hex = 7'h07;
      4'h8:    w_hex = 7'h7F;
      4'h9:    w_hex = 7'h6F;
      4'hA:    w_hex = 7'h77;
      4'hB:    w_hex = 7'h7C;
      4'hC:    w_hex = 7'h39;
      4'hD:    w_hex = 7'h5E;
      4'hE:    w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
  end

  assign w_segRaw = (w_legal && !w_blank) ? w_hex : 7'h00;
  assign w_dpRaw  = w_legal & w_dpBit;

  // Write and swap are mutually exclusive: a write needs pending clear, a swap needs it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadowWord <= 16'h0000;
      r_shadowDp   <= 4'h0;
      r_activeWord <= 16'h0000;
      r_activeDp   <= 4'h0;
      r_pending    <= 1'b0;
      r_prevAn     <= 4'b0001;
      seg          <= SEG_OFF;
      dp           <= DP_OFF;
      an_o         <= 4'b0000;
      frame_start  <= 1'b0;
    end else begin
      r_prevAn    <= an;
      frame_start <= w_fs;
      an_o        <= an;
      seg         <= SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
      dp          <= SEG_ACTIVE_LOW ? ~w_dpRaw : w_dpRaw;
      if (w_wrAccept) begin
        r_shadowWord <= wr_data;
        r_shadowDp   <= wr_dp;
        r_pending    <= 1'b1;
      end else if (w_swap) begin
        r_activeWord <= r_shadowWord;
        r_activeDp   <= r_shadowDp;
        r_pending    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized bench for seg_display_driver: one default instance (active-low, no blanking)
// and one active-high instance with leading-zero blanking, both checked against a word-level model.
module tb_seg_display_driver;

  logic        clk;
  logic        reset;
  logic [3:0]  an;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;

  logic        wr_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an_o;
  logic        frame_start;

  logic        lzReady;
  logic [6:0]  lzSeg;
  logic        lzDp;
  logic [3:0]  lzAnO;
  logic        lzFs;

  int checks = 0;
  int errors = 0;
  int scanPos = 0;

  logic [15:0] mShadow, mActive;
  logic [3:0]  mShadowDp, mActiveDp;
  logic        mPending;
  logic [3:0]  mPrevAn;
  logic [13:0] eMain, eLz;

  logic [6:0] hexTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_display_driver dut (
    .clk(clk), .reset(reset), .an(an), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_ready(wr_ready), .seg(seg), .dp(dp), .an_o(an_o), .frame_start(frame_start)
  );

  seg_display_driver #(.SEG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dutLz (
    .clk(clk), .reset(reset), .an(an), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_ready(lzReady), .seg(lzSeg), .dp(lzDp), .an_o(lzAnO), .frame_start(lzFs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seg, dp} for a displayed word under the given digit select and board options.
  function automatic logic [7:0] expDrive(logic [15:0] w, logic [3:0] d, logic [3:0] a,
                                          bit lz, bit low);
    logic [6:0] s;
    logic p;
    int k;
    int nib;
    s = 7'h00;
    p = 1'b0;
    k = 0;
    if ($countones(a) == 1) begin
      for (int i = 0; i < 4; i++) if (a[i]) k = i;
      nib = int'((w >> (4 * k)) & 16'h000F);
      s = hexTab[nib];
      if (lz && k > 0 && (w >> (4 * k)) == 16'h0000) s = 7'h00;
      p = d[k];
    end
    if (low) begin
      s = ~s;
      p = ~p;
    end
    return {s, p};
  endfunction

  function automatic logic [13:0] gotMain();
    return {seg, dp, an_o, frame_start, wr_ready};
  endfunction

  function automatic logic [13:0] gotLz();
    return {lzSeg, lzDp, lzAnO, lzFs, lzReady};
  endfunction

  task automatic modelReset();
    mShadow   = 16'h0000;
    mShadowDp = 4'h0;
    mActive   = 16'h0000;
    mActiveDp = 4'h0;
    mPending  = 1'b0;
    mPrevAn   = 4'b0001;
    scanPos   = 0;
    an        = 4'b1000;
  endtask

  task automatic nextScan();
    scanPos = (scanPos + 1) % 4;
    an = 4'b1000 >> scanPos;
  endtask

  // One clock edge: the model consumes the pre-edge inputs, then outputs are sampled 1 ns later.
  task automatic applyStimulus();
    logic fsNow, acc, swp;
    @(posedge clk);
    fsNow = (an == 4'b1000) && (mPrevAn == 4'b0001);
    acc   = wr_en && !mPending;
    swp   = fsNow && mPending;
    eMain = {expDrive(mActive, mActiveDp, an, 1'b0, 1'b1), an, fsNow, 1'b0};
    eLz   = {expDrive(mActive, mActiveDp, an, 1'b1, 1'b0), an, fsNow, 1'b0};
    if (acc) begin
      mShadow   = wr_data;
      mShadowDp = wr_dp;
      mPending  = 1'b1;
    end
    if (swp) begin
      mActive   = mShadow;
      mActiveDp = mShadowDp;
      mPending  = 1'b0;
    end
    mPrevAn  = an;
    eMain[0] = !mPending;
    eLz[0]   = !mPending;
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    wr_dp   = 4'h0;
    modelReset();
    #12;
    checks++;
    if (gotMain() !== {7'h7F, 1'b1, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset main got %h want %h", gotMain(), {7'h7F, 1'b1, 4'b0000, 1'b0, 1'b1});
    end
    checks++;
    if (gotLz() !== {7'h00, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset lz got %h want %h", gotLz(), {7'h00, 1'b0, 4'b0000, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL idle main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL idle lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        wr_en   = 1'b1;
        wr_data = 16'h12AF;
        wr_dp   = 4'b0010;
      end
      applyStimulus();
      wr_en = 1'b0;
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL write main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL write lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        wr_en   = 1'b1;
        wr_data = 16'($urandom);
        wr_dp   = 4'($urandom);
      end else if (i == 1) begin
        wr_en   = 1'b1;
        wr_data = 16'h5555;
        wr_dp   = 4'hF;
      end
      applyStimulus();
      wr_en = 1'b0;
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL b2b main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL b2b lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_write_on_fs();
    int budget;
    budget = 0;
    while ((mPending || scanPos != 0) && budget < 16) begin
      applyStimulus();
      nextScan();
      budget++;
    end
    checks++;
    if (mPending || scanPos != 0) begin
      errors++;
      $display("[TB] FAIL fs-align budget got pending=%b pos=%0d want 0/0", mPending, scanPos);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        wr_en   = 1'b1;
        wr_data = 16'h3C9E;
        wr_dp   = 4'b1001;
      end
      applyStimulus();
      wr_en = 1'b0;
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL wr-on-fs main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL wr-on-fs lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_lz();
    logic [15:0] words [3] = '{16'h0070, 16'h0000, 16'h0F00};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 12; i++) begin
        if (i == 0) begin
          wr_en   = 1'b1;
          wr_data = words[w];
          wr_dp   = 4'b0100;
        end
        applyStimulus();
        wr_en = 1'b0;
        checks++;
        if (gotMain() !== eMain) begin
          errors++;
          $display("[TB] FAIL lz-word%0d main cyc %0d got %h want %h", w, i, gotMain(), eMain);
        end
        checks++;
        if (gotLz() !== eLz) begin
          errors++;
          $display("[TB] FAIL lz-word%0d lz cyc %0d got %h want %h", w, i, gotLz(), eLz);
        end
        nextScan();
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2] = '{4'b1100, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      if (i < 2) an = bad[i];
      applyStimulus();
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL illegal main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL illegal lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 16'($urandom);
      wr_dp   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) an = 4'($urandom_range(0, 15));
      applyStimulus();
      wr_en = 1'b0;
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL random main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL random lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    budget = 0;
    while (mPending && budget < 16) begin
      applyStimulus();
      nextScan();
      budget++;
    end
    wr_en   = 1'b1;
    wr_data = 16'hBEEF;
    wr_dp   = 4'hF;
    applyStimulus();
    wr_en = 1'b0;
    checks++;
    if (gotMain() !== eMain) begin
      errors++;
      $display("[TB] FAIL rstmid-write main got %h want %h", gotMain(), eMain);
    end
    nextScan();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gotMain() !== {7'h7F, 1'b1, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rstmid async main got %h want %h", gotMain(), {7'h7F, 1'b1, 4'b0000, 1'b0, 1'b1});
    end
    checks++;
    if (gotLz() !== {7'h00, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rstmid async lz got %h want %h", gotLz(), {7'h00, 1'b0, 4'b0000, 1'b0, 1'b1});
    end
    modelReset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus();
      checks++;
      if (gotMain() !== eMain) begin
        errors++;
        $display("[TB] FAIL rstmid after main cyc %0d got %h want %h", i, gotMain(), eMain);
      end
      checks++;
      if (gotLz() !== eLz) begin
        errors++;
        $display("[TB] FAIL rstmid after lz cyc %0d got %h want %h", i, gotLz(), eLz);
      end
      nextScan();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write();
    test_back_to_back();
    test_write_on_fs();
    test_lz();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
